fifo_read_ctrl: RTL and testbench

//  Read-side consumer for the dual-clock fifo; runs entirely in the read_clock domain.

---
 rtl/fifo_read_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_read_ctrl
//  Purpose  : Read-side consumer for the dual-clock fifo. Runs entirely in the
//             read clock domain: watches the fifo empty/almost-empty flags,
//             issues read strobes in bursts, captures the returning fifo
//             word one cycle later and presents words downstream through a
//             2-entry skid buffer with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SIZE   data width in bits (must match the fifo data width)
//    BURST  maximum reads per burst before a mandatory 1-cycle gap (1..255)
//  Ports
//    read_clock        in   1     clock, all state on rising edge
//    reset_n           in   1     asynchronous active-low reset
//    empty_flag        in   1     fifo empty
//    almost_empty_flag in   1     fifo holds exactly one word
//    fifo_data         in   SIZE  fifo data_out, valid 1 cycle after valid_read
//    valid_read        out  1     read strobe to fifo, one word per high cycle
//    data_out          out  SIZE  head of skid buffer
//    data_valid        out  1     data_out holds a word
//    data_ready        in   1     downstream accepts on data_valid && data_ready
//    busy              out  1     controller active, read in flight or data held
//    read_count        out  16    (FIFO_READ_CTRL_COUNT_EN only) saturating
//                                 count of downstream handshakes
//  Configuration macro
//    FIFO_READ_CTRL_COUNT_EN : adds the read_count output and its counter.
// ============================================================================
module fifo_read_ctrl #(
    parameter int SIZE  = 8,
    parameter int BURST = 4
) (
    input  logic            read_clock,
    input  logic            reset_n,
    input  logic            empty_flag,
    input  logic            almost_empty_flag,
    input  logic [SIZE-1:0] fifo_data,
    output logic            valid_read,
    output logic [SIZE-1:0] data_out,
    output logic            data_valid,
    input  logic            data_ready,
    output logic            busy
`ifdef FIFO_READ_CTRL_COUNT_EN
    ,
    output logic [15:0]     read_count
`endif
);

    localparam logic [7:0] BURST_LIM = 8'(BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic            hold_q, hold_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      occ_q, occ_d;
    logic [SIZE-1:0] head_q, head_d;
    logic [SIZE-1:0] tail_q, tail_d;
    logic            data_valid_q, data_valid_d;

    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [2:0]      w_load;
    logic            w_credit;

    // ------------------------------------------------------------------------
    // Handshake and credit.
    // A word already in flight will land in the buffer next cycle, so it is
    // counted against the two buffer slots; a pop this cycle frees one slot.
    // ------------------------------------------------------------------------
    assign w_pop    = data_valid_q && data_ready;
    assign w_push   = inflight_q;
    assign w_load   = {1'b0, occ_q} + {2'b00, inflight_q};
    assign w_credit = (w_load < (3'd2 + {2'b00, w_pop}));

    // ------------------------------------------------------------------------
    // Burst FSM: next state and read strobe
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        w_issue     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_flag) begin
                    state_d     = ST_BURST;
                    burst_cnt_d = 8'd0;
                end
            end

            ST_BURST: begin
                // The count guard keeps burst_cnt from ever passing BURST.
                w_issue = !empty_flag && w_credit && !hold_q &&
                          (burst_cnt_q < BURST_LIM);
                if (w_issue) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                if (empty_flag || (burst_cnt_d == BURST_LIM)) begin
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign valid_read = w_issue;
    assign inflight_d = w_issue;
    // Reading the last word: pause one cycle so the fifo's empty flag can
    // catch up before another read is considered.
    assign hold_d     = w_issue && almost_empty_flag;

    // ------------------------------------------------------------------------
    // Two-entry skid buffer, strict FIFO order. head_q is the word shown on
    // data_out; tail_q holds the second word when occ_q == 2.
    // ------------------------------------------------------------------------
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;

        case ({w_push, w_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_data;
                end else begin
                    tail_d = fifo_data;
                end
                occ_d = occ_q + 2'd1;
            end

            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end

            2'b11: begin
                // Occupancy unchanged: the popped head is replaced by the
                // next oldest word.
                if (occ_q == 2'd1) begin
                    head_d = fifo_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_data;
                end
            end

            default: begin
            end
        endcase

        data_valid_d = (occ_d != 2'd0);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge read_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= 8'd0;
            hold_q       <= 1'b0;
            inflight_q   <= 1'b0;
            occ_q        <= 2'd0;
            head_q       <= '0;
            tail_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            hold_q       <= hold_d;
            inflight_q   <= inflight_d;
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = head_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q != ST_IDLE) || inflight_q || (occ_q != 2'd0);

`ifdef FIFO_READ_CTRL_COUNT_EN
    // ------------------------------------------------------------------------
    // Saturating handshake counter
    // ------------------------------------------------------------------------
    logic [15:0] read_count_q;

    always_ff @(posedge read_clock or negedge reset_n) begin
        if (!reset_n) begin
            read_count_q <= 16'd0;
        end else if (w_pop && (read_count_q != 16'hFFFF)) begin
            read_count_q <= read_count_q + 16'd1;
        end
    end

    assign read_count = read_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_read_ctrl
//  Purpose  : Self-checking bench for fifo_read_ctrl. Cycle-exact table of
//             directed vectors plus hand-written sequences driven by a small
//             fifo model for the back-pressure and counter cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

    localparam int SIZE  = 10;
    localparam int BURST = 4;

    logic            clk;
    logic            reset_n;
    logic            empty_flag;
    logic            almost_empty_flag;
    logic [SIZE-1:0] fifo_data;
    logic            valid_read;
    logic [SIZE-1:0] data_out;
    logic            data_valid;
    logic            data_ready;
    logic            busy;
`ifdef FIFO_READ_CTRL_COUNT_EN
    logic [15:0]     read_count;
`endif

    int errors = 0;
    int checks = 0;

    fifo_read_ctrl #(
        .SIZE  (SIZE),
        .BURST (BURST)
    ) dut (
        .read_clock        (clk),
        .reset_n           (reset_n),
        .empty_flag        (empty_flag),
        .almost_empty_flag (almost_empty_flag),
        .fifo_data         (fifo_data),
        .valid_read        (valid_read),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .busy              (busy)
`ifdef FIFO_READ_CTRL_COUNT_EN
        ,
        .read_count        (read_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic            rst_n;
        logic            empty;
        logic            almost;
        logic            rdy;
        logic [SIZE-1:0] fd;
        logic            vr;
        logic            dv;
        logic            cdo;
        logic [SIZE-1:0] dout;
        logic            bsy;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic e, input logic a, input logic rd,
                       input int fd, input logic vr, input logic dv, input logic cdo,
                       input int dout, input logic bsy);
        vec_t v;
        v.rst_n  = r;
        v.empty  = e;
        v.almost = a;
        v.rdy    = rd;
        v.fd     = SIZE'(fd);
        v.vr     = vr;
        v.dv     = dv;
        v.cdo    = cdo;
        v.dout   = SIZE'(dout);
        v.bsy    = bsy;
        vt.push_back(v);
    endtask

    // ------------------------------------------------------------------------
    // Fifo model used by the hand-written sequences
    // ------------------------------------------------------------------------
    logic [SIZE-1:0] fq[$];
    logic [SIZE-1:0] rxq[$];
    int              nreads;

    task automatic mcycle();
        logic            rd;
        logic [SIZE-1:0] nd;
        nd = '0;
        @(negedge clk);
        empty_flag        = (fq.size() == 0);
        almost_empty_flag = (fq.size() == 1);
        #1;
        if (data_valid && data_ready) rxq.push_back(data_out);
        rd = valid_read;
        if (rd) begin
            nreads++;
            if (fq.size() > 0) begin
                nd = fq.pop_front();
            end else begin
                chk("read_while_empty", 16'(rd), 16'd0);
            end
        end
        @(posedge clk);
        #1;
        if (rd) fifo_data = nd;
    endtask

    initial begin
        reset_n           = 1'b0;
        empty_flag        = 1'b0;
        almost_empty_flag = 1'b0;
        fifo_data         = '0;
        data_ready        = 1'b1;
        nreads            = 0;

        // Reset held with fifo non-empty
        add(0,0,0,1,   0,  0,0,1,   0, 0);
        add(0,0,0,1,   0,  0,0,1,   0, 0);
        // Six-word burst: 4 reads, gap, idle, 2 reads
        add(1,0,0,1,   0,  0,0,0,   0, 0);
        add(1,0,0,1,   0,  1,0,0,   0, 1);
        add(1,0,0,1,  21,  1,0,0,   0, 1);
        add(1,0,0,1, 503,  1,1,1,  21, 1);
        add(1,0,0,1,  90,  1,1,1, 503, 1);
        add(1,0,0,1,  10,  0,1,1,  90, 1);
        add(1,0,0,1,   0,  0,1,1,  10, 1);
        add(1,0,0,1,   0,  1,0,0,   0, 1);
        add(1,0,1,1,  20,  1,0,0,   0, 1);
        add(1,1,0,1, 820,  0,1,1,  20, 1);
        add(1,1,0,1,   0,  0,1,1, 820, 1);
        add(1,1,0,1,   0,  0,0,0,   0, 0);
        // Single word with a lagging empty flag: hold blocks a second read
        add(1,0,1,1,   0,  0,0,0,   0, 0);
        add(1,0,1,1,   0,  1,0,0,   0, 1);
        add(1,0,1,1,  77,  0,0,0,   0, 1);
        add(1,1,0,1,   0,  0,1,1,  77, 1);
        add(1,1,0,1,   0,  0,0,0,   0, 1);
        add(1,1,0,1,   0,  0,0,0,   0, 0);
        // Reset with one word buffered and one in flight
        add(1,0,0,0,   0,  0,0,0,   0, 0);
        add(1,0,0,0,   0,  1,0,0,   0, 1);
        add(1,0,0,0,  55,  1,0,0,   0, 1);
        add(0,0,0,0,  66,  0,0,1,   0, 0);
        add(1,1,0,0,  66,  0,0,1,   0, 0);
        add(1,1,0,0,   0,  0,0,1,   0, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            reset_n           = vt[i].rst_n;
            empty_flag        = vt[i].empty;
            almost_empty_flag = vt[i].almost;
            data_ready        = vt[i].rdy;
            fifo_data         = vt[i].fd;
            #1;
            chk($sformatf("v%0d.valid_read", i), 16'(valid_read), 16'(vt[i].vr));
            chk($sformatf("v%0d.data_valid", i), 16'(data_valid), 16'(vt[i].dv));
            chk($sformatf("v%0d.busy", i),       16'(busy),       16'(vt[i].bsy));
            if (vt[i].cdo) begin
                chk($sformatf("v%0d.data_out", i), 16'(data_out), 16'(vt[i].dout));
            end
        end

        // --------------------------------------------------------------------
        // Back-pressure: 5 words, ready low -> exactly 2 reads, head held
        // --------------------------------------------------------------------
        begin
            logic [SIZE-1:0] exp_w[5];
            int              cyc;
            exp_w = '{SIZE'(101), SIZE'(102), SIZE'(103), SIZE'(104), SIZE'(105)};
            fq.delete();
            rxq.delete();
            foreach (exp_w[k]) fq.push_back(exp_w[k]);
            nreads     = 0;
            data_ready = 1'b0;
            for (int c = 0; c < 8; c++) begin
                mcycle();
                if (data_valid) chk("stall.head_stable", 16'(data_out), 16'd101);
            end
            chk("stall.reads", 16'(nreads), 16'd2);
            chk("stall.occ", 16'(dut.occ_q), 16'd2);
            chk("stall.data_valid", 16'(data_valid), 16'd1);
            chk("stall.data_out", 16'(data_out), 16'd101);

            data_ready = 1'b1;
            cyc = 0;
            while ((rxq.size() < 5) && (cyc < 40)) begin
                mcycle();
                cyc++;
            end
            for (int c = 0; c < 4; c++) mcycle();
            chk("release.received", 16'(rxq.size()), 16'd5);
            chk("release.reads", 16'(nreads), 16'd5);
            for (int k = 0; k < 5; k++) begin
                if (k < rxq.size()) begin
                    chk($sformatf("release.word%0d", k), 16'(rxq[k]), 16'(exp_w[k]));
                end
            end
            chk("release.busy", 16'(busy), 16'd0);
        end

`ifdef FIFO_READ_CTRL_COUNT_EN
        // --------------------------------------------------------------------
        // Handshake counter: 9 words, then saturation from 16'hFFFE
        // --------------------------------------------------------------------
        begin
            int cyc;
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            chk("cnt.reset", read_count, 16'd0);
            @(negedge clk);
            reset_n = 1'b1;
            fq.delete();
            rxq.delete();
            for (int k = 0; k < 9; k++) fq.push_back(SIZE'(200 + k));
            data_ready = 1'b1;
            cyc = 0;
            while ((rxq.size() < 9) && (cyc < 80)) begin
                mcycle();
                cyc++;
            end
            for (int c = 0; c < 4; c++) mcycle();
            chk("cnt.nine", read_count, 16'd9);

            @(negedge clk);
            force dut.read_count_q = 16'hFFFE;
            @(posedge clk);
            #1;
            release dut.read_count_q;
            rxq.delete();
            for (int k = 0; k < 3; k++) fq.push_back(SIZE'(300 + k));
            cyc = 0;
            while ((rxq.size() < 3) && (cyc < 40)) begin
                mcycle();
                cyc++;
            end
            for (int c = 0; c < 4; c++) mcycle();
            chk("cnt.saturate", read_count, 16'hFFFF);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
